// File: rtl/multicycle_ctrl_v3.sv
// Multi-cycle control unit with memory wait handshake, resumable STOP, illegal-opcode TRAP and saturating counters.
// Optional BRANCH_STATS_EN adds a saturating taken-branch counter output (taken_count).
module multicycle_ctrl_v3 #(
  parameter int CNT_W               = 16,
  parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             N,
  input  logic             Z,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             PCwrite,
  output logic             AddrSel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRload,
  output logic             R1Sel,
  output logic             MDRload,
  output logic             R1R2Load,
  output logic             ALU1,
  output logic             ALUOutWrite,
  output logic             RFWrite,
  output logic             RegIn,
  output logic             FlagWrite,
  output logic [2:0]       ALU2,
  output logic [2:0]       ALUop,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_count
`endif
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_ASN, S_SHIFT, S_WB,
    S_ORI1, S_ORI2, S_ORI3, S_LD1, S_LD2, S_ST,
    S_BPZ, S_BZ, S_BNZ, S_NOP, S_STOP, S_TRAP
  } state_t;

  state_t state;
  logic   mem_rdy;
  logic   retire_inc;

  // With the wait handshake disabled every memory access completes in one cycle.
  assign mem_rdy = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;

  function automatic state_t decode_op(input logic [3:0] op);
    state_t s;
    case (op)
      4'b0100, 4'b0110, 4'b1000: s = S_ASN;
      4'b0000: s = S_LD1;
      4'b0010: s = S_ST;
      4'b1101: s = S_BPZ;
      4'b0101: s = S_BZ;
      4'b1001: s = S_BNZ;
      4'b1010: s = S_NOP;
      4'b0001: s = S_STOP;
      default: begin
        if (op[2:0] == 3'b011)      s = S_SHIFT;
        else if (op[2:0] == 3'b111) s = S_ORI1;
        else                        s = S_TRAP;
      end
    endcase
    return s;
  endfunction

  always_comb begin
    PCwrite     = 1'b0;
    AddrSel     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRload      = 1'b0;
    R1Sel       = 1'b0;
    MDRload     = 1'b0;
    R1R2Load    = 1'b0;
    ALU1        = 1'b0;
    ALUOutWrite = 1'b0;
    RFWrite     = 1'b0;
    RegIn       = 1'b0;
    FlagWrite   = 1'b0;
    ALU2        = 3'b000;
    ALUop       = 3'b000;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        AddrSel = 1'b1;
        MemRead = 1'b1;
        ALU2    = 3'b001;
        PCwrite = mem_rdy;
        IRload  = mem_rdy;
      end
      S_DECODE: R1R2Load = 1'b1;
      S_ASN: begin
        ALU1        = 1'b1;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        if (instr == 4'b0110)      ALUop = 3'b001;
        else if (instr == 4'b1000) ALUop = 3'b011;
        else                       ALUop = 3'b000;
      end
      S_SHIFT: begin
        ALU1        = 1'b1;
        ALU2        = 3'b100;
        ALUop       = 3'b100;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      S_WB: RFWrite = 1'b1;
      S_ORI1: begin
        R1Sel    = 1'b1;
        R1R2Load = 1'b1;
      end
      S_ORI2: begin
        ALU1        = 1'b1;
        ALU2        = 3'b011;
        ALUop       = 3'b010;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      S_ORI3: begin
        R1Sel   = 1'b1;
        RFWrite = 1'b1;
      end
      S_LD1: begin
        MemRead = 1'b1;
        MDRload = mem_rdy;
      end
      S_LD2: begin
        RegIn       = 1'b1;
        RFWrite     = 1'b1;
        ALUOutWrite = 1'b1;
      end
      S_ST: MemWrite = 1'b1;
      S_BPZ: begin
        ALU2    = 3'b010;
        PCwrite = ~N;
      end
      S_BZ: begin
        ALU2    = 3'b010;
        PCwrite = Z;
      end
      S_BNZ: begin
        ALU2    = 3'b010;
        PCwrite = ~Z;
      end
      S_STOP:  halted  = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires on the edge that completes it; stop retires as it enters STOP.
  always_comb begin
    retire_inc = 1'b0;
    case (state)
      S_WB, S_ORI3, S_LD2, S_BPZ, S_BZ, S_BNZ, S_NOP: retire_inc = 1'b1;
      S_ST:     retire_inc = mem_rdy;
      S_DECODE: retire_inc = (instr == 4'b0001);
      default:  retire_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_RESET;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      if (state != S_STOP && state != S_TRAP && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (retire_inc && retire_count != '1)
        retire_count <= retire_count + 1'b1;
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (mem_rdy) state <= S_DECODE;
        S_DECODE: state <= decode_op(instr);
        S_ASN, S_SHIFT: state <= S_WB;
        S_ORI1:   state <= S_ORI2;
        S_ORI2:   state <= S_ORI3;
        S_LD1:    if (mem_rdy) state <= S_LD2;
        S_ST:     if (mem_rdy) state <= S_FETCH;
        S_STOP:   if (resume) state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        S_WB, S_ORI3, S_LD2, S_BPZ, S_BZ, S_BNZ, S_NOP: state <= S_FETCH;
        default:  state <= S_RESET;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      taken_count <= '0;
    else if ((state == S_BPZ || state == S_BZ || state == S_BNZ) && PCwrite && taken_count != '1)
      taken_count <= taken_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v3.sv
// Directed self-checking bench for multicycle_ctrl_v3: default instance plus a CNT_W=2, no-wait instance.
module tb_multicycle_ctrl_v3;

  logic clock = 1'b0;
  logic reset, reset_s;
  logic [3:0] instr, instr_s;
  logic N, Z, mem_ready, resume;

  logic PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load;
  logic ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, halted, illegal;
  logic [2:0] ALU2, ALUop;
  logic [15:0] cycle_count, retire_count;

  logic s_PCwrite, s_AddrSel, s_MemRead, s_MemWrite, s_IRload, s_R1Sel, s_MDRload, s_R1R2Load;
  logic s_ALU1, s_ALUOutWrite, s_RFWrite, s_RegIn, s_FlagWrite, s_halted, s_illegal;
  logic [2:0] s_ALU2, s_ALUop;
  logic [1:0] s_cycle_count, s_retire_count;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [1:0]  s_taken_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [18:0] ctrl;
  assign ctrl = {PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
                 ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop};

  localparam logic [18:0] C_PCW  = 19'h40000;
  localparam logic [18:0] C_ADDR = 19'h20000;
  localparam logic [18:0] C_MRD  = 19'h10000;
  localparam logic [18:0] C_MWR  = 19'h08000;
  localparam logic [18:0] C_IRL  = 19'h04000;
  localparam logic [18:0] C_R1S  = 19'h02000;
  localparam logic [18:0] C_MDR  = 19'h01000;
  localparam logic [18:0] C_R12  = 19'h00800;
  localparam logic [18:0] C_ALU1 = 19'h00400;
  localparam logic [18:0] C_AOW  = 19'h00200;
  localparam logic [18:0] C_RFW  = 19'h00100;
  localparam logic [18:0] C_RIN  = 19'h00080;
  localparam logic [18:0] C_FW   = 19'h00040;

  localparam logic [18:0] F_RDY  = C_PCW | C_ADDR | C_MRD | C_IRL | 19'h00008;
  localparam logic [18:0] F_WAIT = C_ADDR | C_MRD | 19'h00008;

  multicycle_ctrl_v3 dut (
    .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z),
    .mem_ready(mem_ready), .resume(resume),
    .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRload(IRload), .R1Sel(R1Sel), .MDRload(MDRload), .R1R2Load(R1R2Load),
    .ALU1(ALU1), .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn),
    .FlagWrite(FlagWrite), .ALU2(ALU2), .ALUop(ALUop), .halted(halted),
    .illegal(illegal), .cycle_count(cycle_count), .retire_count(retire_count)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count)
`endif
  );

  multicycle_ctrl_v3 #(.CNT_W(2), .MEM_WAIT_EN_DEFAULT(1'b0)) dut_small (
    .clock(clock), .reset(reset_s), .instr(instr_s), .N(N), .Z(Z),
    .mem_ready(mem_ready), .resume(resume),
    .PCwrite(s_PCwrite), .AddrSel(s_AddrSel), .MemRead(s_MemRead), .MemWrite(s_MemWrite),
    .IRload(s_IRload), .R1Sel(s_R1Sel), .MDRload(s_MDRload), .R1R2Load(s_R1R2Load),
    .ALU1(s_ALU1), .ALUOutWrite(s_ALUOutWrite), .RFWrite(s_RFWrite), .RegIn(s_RegIn),
    .FlagWrite(s_FlagWrite), .ALU2(s_ALU2), .ALUop(s_ALUop), .halted(s_halted),
    .illegal(s_illegal), .cycle_count(s_cycle_count), .retire_count(s_retire_count)
`ifdef BRANCH_STATS_EN
    , .taken_count(s_taken_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts in FETCH with mem_ready high and leaves the DUT in the opcode's first execute state.
  task automatic applyStimulus(input logic [3:0] op);
    instr = op;
    #1;
    checkOutput("fetch", ctrl, F_RDY);
    tick();
    checkOutput("decode", ctrl, C_R12);
    tick();
  endtask

  logic [3:0] asn_op  [2] = '{4'b0110, 4'b1000};
  logic [2:0] asn_alu [2] = '{3'b001, 3'b011};
  logic [3:0] br_op   [6] = '{4'b0101, 4'b0101, 4'b1001, 4'b1001, 4'b1101, 4'b1101};
  logic       br_n    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       br_z    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       br_pcw  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; reset_s = 1'b1;
    instr = 4'b0000; instr_s = 4'b1010;
    N = 1'b0; Z = 1'b0; mem_ready = 1'b1; resume = 1'b0;
    tick(); tick();
    checkOutput("reset_ctrl", ctrl, 19'h0);
    checkOutput("reset_cycle", cycle_count, 0);
    checkOutput("reset_retire", retire_count, 0);
    checkOutput("reset_flags", {halted, illegal}, 2'b00);
    reset = 1'b0; reset_s = 1'b0;
    tick();

    applyStimulus(4'b0100);
    checkOutput("asn_add", ctrl, C_ALU1 | C_AOW | C_FW);
    tick();
    checkOutput("wb", ctrl, C_RFW);
    checkOutput("wb_retire", retire_count, 0);
    tick();
    checkOutput("add_cycle", cycle_count, 5);
    checkOutput("add_retire", retire_count, 1);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(asn_op[i]);
      checkOutput("asn_op", ctrl, C_ALU1 | C_AOW | C_FW | {16'h0, asn_alu[i]});
      tick(); tick();
    end
    checkOutput("asn_cycle", cycle_count, 13);
    checkOutput("asn_retire", retire_count, 3);

    applyStimulus(4'b0011);
    checkOutput("shift", ctrl, C_ALU1 | C_AOW | C_FW | 19'h00024);
    tick(); tick();

    applyStimulus(4'b1111);
    checkOutput("ori1", ctrl, C_R1S | C_R12);
    tick();
    checkOutput("ori2", ctrl, C_ALU1 | C_AOW | C_FW | 19'h0001A);
    tick();
    checkOutput("ori3", ctrl, C_R1S | C_RFW);
    tick();
    checkOutput("ori_cycle", cycle_count, 22);
    checkOutput("ori_retire", retire_count, 5);

    applyStimulus(4'b0000);
    mem_ready = 1'b0;
    #1;
    checkOutput("ld1_wait", ctrl, C_MRD);
    repeat (2) begin
      tick();
      checkOutput("ld1_wait", ctrl, C_MRD);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("ld1_ready", ctrl, C_MRD | C_MDR);
    tick();
    checkOutput("ld2", ctrl, C_RIN | C_RFW | C_AOW);
    tick();
    checkOutput("ld_cycle", cycle_count, 28);
    checkOutput("ld_retire", retire_count, 6);

    mem_ready = 1'b0;
    #1;
    checkOutput("fetch_wait", ctrl, F_WAIT);
    tick();
    checkOutput("fetch_hold", ctrl, F_WAIT);
    checkOutput("fetch_wait_cycle", cycle_count, 29);
    mem_ready = 1'b1;
    applyStimulus(4'b0010);
    mem_ready = 1'b0;
    #1;
    checkOutput("st_wait", ctrl, C_MWR);
    tick();
    checkOutput("st_hold", ctrl, C_MWR);
    checkOutput("st_wait_retire", retire_count, 6);
    mem_ready = 1'b1;
    #1;
    checkOutput("st_ready", ctrl, C_MWR);
    tick();
    checkOutput("st_retire", retire_count, 7);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(br_op[i]);
      N = br_n[i]; Z = br_z[i];
      #1;
      checkOutput("branch", ctrl, 19'h00010 | (br_pcw[i] ? C_PCW : 19'h0));
      tick();
`ifdef BRANCH_STATS_EN
      if (i == 1) checkOutput("taken_first", taken_count, 1);
`endif
    end
    checkOutput("br_cycle", cycle_count, 51);
    checkOutput("br_retire", retire_count, 13);
`ifdef BRANCH_STATS_EN
    checkOutput("taken_total", taken_count, 3);
`endif

    applyStimulus(4'b1010);
    checkOutput("nop", ctrl, 19'h0);
    tick();
    resume = 1'b1; mem_ready = 1'b0;
    tick();
    checkOutput("resume_ignored", {ctrl, halted}, {F_WAIT, 1'b0});
    checkOutput("resume_ign_cycle", cycle_count, 55);
    resume = 1'b0; mem_ready = 1'b1;

    applyStimulus(4'b0001);
    checkOutput("stop_halted", {halted, illegal}, 2'b10);
    checkOutput("stop_ctrl", ctrl, 19'h0);
    checkOutput("stop_retire", retire_count, 15);
    repeat (10) tick();
    checkOutput("stop_frozen", cycle_count, 57);
    checkOutput("stop_still", halted, 1'b1);
    instr = 4'b1100;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    checkOutput("resume_fetch", {ctrl, halted}, {F_RDY, 1'b0});
    checkOutput("resume_cycle", cycle_count, 57);
    tick();
    checkOutput("resume_counting", cycle_count, 58);
    tick();
    checkOutput("trap_flags", {halted, illegal}, 2'b01);
    checkOutput("trap_ctrl", ctrl, 19'h0);
    resume = 1'b1;
    repeat (3) tick();
    checkOutput("trap_absorb", illegal, 1'b1);
    checkOutput("trap_cycle", cycle_count, 59);
    checkOutput("trap_retire", retire_count, 15);
    resume = 1'b0;

    reset = 1'b1;
    #1;
    checkOutput("rst_trap_flags", {halted, illegal}, 2'b00);
    checkOutput("rst_trap_cycle", cycle_count, 0);
    checkOutput("rst_trap_retire", retire_count, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_fetch", ctrl, F_RDY);
    checkOutput("rst_fetch_cycle", cycle_count, 1);

    checkOutput("small_cycle_sat", s_cycle_count, 3);
    checkOutput("small_retire_sat", s_retire_count, 3);
    checkOutput("small_flags", {s_halted, s_illegal}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_v3.md
Name: multicycle_ctrl_v3

Overview:
Parametrised successor to the 4-bit-opcode multi-cycle control unit. It drives the same datapath control signals and adds three things:
- a memory ready/wait handshake on fetch, load and store;
- resumable STOP, plus a sticky illegal-opcode trap;
- parametrised saturating cycle and retired-instruction counters.

It sits between IR/flags and the datapath, in place of the previous controller.

Parameters:
CNT_W, 16, width of cycle_count and retire_count (min 2)
MEM_WAIT_EN_DEFAULT, 1, 1 = honour mem_ready; 0 = treat mem_ready as always 1

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
instr  in  4  IR opcode field
N  in  1  negative flag
Z  in  1  zero flag
mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
resume  in  1  leave STOP on next edge
PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite  out  1 each  datapath controls
ALU2  out  3  ALU B-mux select
ALUop  out  3  ALU operation
halted  out  1  high in STOP
illegal  out  1  high in TRAP
cycle_count  out  CNT_W  cycles since reset, excluding STOP/TRAP; saturates at all-ones
retire_count  out  CNT_W  instructions completed; saturates

Behaviour:
- Reset:
  - state RESET; both counters 0.
  - All outputs 0 in RESET.
- Outputs are Moore/decoded from state (plus instr and flags in EXEC states). Every output is assigned in every state; no latches.
- Decode map:
  - 0100 add, 0110 sub, 1000 nand
  - instr[2:0]=011 shift, instr[2:0]=111 ori
  - 0000 load, 0010 store
  - 1101 bpz, 0101 bz, 1001 bnz
  - 1010 nop, 0001 stop
  - anything else → TRAP
- Transitions:
  - RESET→FETCH.
  - FETCH holds until mem_ready, then →DECODE.
  - DECODE→ the opcode's C3 state.
  - ASN, SHIFT→WB; WB→FETCH.
  - ORI1→ORI2→ORI3→FETCH.
  - LD1 holds until mem_ready, then →LD2→FETCH.
  - ST holds until mem_ready, then →FETCH.
  - BPZ/BZ/BNZ/NOP→FETCH.
  - STOP→FETCH when resume=1.
  - TRAP is absorbing until reset.
- Control values (unlisted signals 0):
  - FETCH: AddrSel=1, MemRead=1, ALU2=001, ALUop=000. PCwrite=IRload=mem_ready, so the PC and IR update exactly once per fetch.
  - DECODE: R1R2Load=1.
  - ASN: ALU1=1, ALU2=000, ALUOutWrite=1, FlagWrite=1. ALUop is 000 add / 001 sub / 011 nand.
  - SHIFT: ALU1=1, ALU2=100, ALUop=100, ALUOutWrite=1, FlagWrite=1.
  - WB: RFWrite=1.
  - ORI1: R1Sel=1, R1R2Load=1.
  - ORI2: ALU1=1, ALU2=011, ALUop=010, ALUOutWrite=1, FlagWrite=1.
  - ORI3: R1Sel=1, RFWrite=1.
  - LD1: MemRead=1, MDRload=mem_ready.
  - LD2: RegIn=1, RFWrite=1, ALUOutWrite=1.
  - ST: MemWrite=1, held while waiting.
  - BPZ/BZ/BNZ: ALU2=010. PCwrite=~N / Z / ~Z, sampled combinationally in that cycle.
- Counters:
  - cycle_count increments on every edge except in STOP and TRAP.
  - retire_count increments on the edge leaving WB, ORI3, LD2, ST (when mem_ready) and BPZ/BZ/BNZ/NOP.
  - Entering STOP counts stop as retired.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- Boundaries:
  - mem_ready low indefinitely: the wait state holds with its outputs stable.
  - resume asserted outside STOP: ignored.
  - reset mid-wait or in TRAP: immediately back to RESET with counters 0.
  - halted=1 exactly in STOP; illegal=1 exactly in TRAP.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds output taken_count [CNT_W-1:0]. It increments (saturating) on each BPZ/BZ/BNZ cycle where PCwrite=1, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- add (0100), mem_ready=1 → FETCH, DECODE, ASN (ALUop=000), WB, FETCH; retire_count 0→1; cycle_count=5 after reset release + 5 edges.
- load with mem_ready low for 3 cycles in LD1 → MemRead held, MDRload=0 for 3 cycles then 1; LD2 asserts RegIn=RFWrite=1.
- bz with Z=0 then Z=1 → PCwrite 0 then 1 with ALU2=010; bnz mirrors it; with BRANCH_STATS_EN, taken_count=1 after the Z=1 bz.
- stop (0001) → halted=1, cycle_count frozen for 10 cycles; resume pulse → FETCH next edge, counting resumes.
- opcode 1111→ori path; opcode 1100 → TRAP, illegal=1, all controls 0; reset pulse → RESET, illegal=0.
- CNT_W=2, run 6 nops → cycle_count and retire_count stick at 3.
